// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch unit: request/accept handshake plus a
// separate read-data return channel.
interface fetch_unit_if;
    // A request transfers on a cycle where imem_req and imem_ready are both 1;
    // imem_addr is held stable while imem_req waits for imem_ready.
    // Read data returns later on a cycle with imem_rvalid=1.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: fetches one word, holds it for
// decode/execute, then advances the PC sequentially or to a PC-relative target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_unit_if.master imem,
    input  logic        exec_done,
    input  logic        PCSrc,
    input  logic [31:0] ImmExt,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [31:0] pc_out,
    output logic        fault,
    output logic [31:0] instret,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        fetch_req;
    logic        capture;
    logic        retire;
    logic [31:0] pc_target;
    logic        misaligned;

    always_comb begin
        pc_target  = PCSrc ? (pc_out + ImmExt) : (pc_out + 32'd4);
        misaligned = |pc_target[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // rvalid is only honoured in WAIT, so responses in any other state drop.
    always_comb begin
        state_next = state;
        fetch_req  = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                fetch_req = 1'b1;
                if (imem.imem_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (exec_done) begin
                    retire     = 1'b1;
                    state_next = misaligned ? ERROR : FETCH;
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out      <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            instret     <= 32'd0;
        end else begin
            if (capture) begin
                instr       <= imem.imem_rdata;
                instr_valid <= 1'b1;
            end
            // A misaligned target still retires the instruction and is kept in pc_out.
            if (retire) begin
                pc_out      <= pc_target;
                instret     <= instret + 32'd1;
                instr_valid <= 1'b0;
                if (misaligned) begin
                    fault <= 1'b1;
                end
            end
        end
    end

    assign imem.imem_req  = fetch_req;
    assign imem.imem_addr = pc_out;
    assign opcode         = instr[6:0];
    assign func3          = instr[14:12];
    assign func7          = instr[31:25];
    assign fsm_state      = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential/taken flow, backpressure,
// stall, instret wrap, misalignment and mid-fetch reset.
module tb_fetch_unit;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    logic        clk;
    logic        rst_n;
    logic        exec_done;
    logic        PCSrc;
    logic [31:0] ImmExt;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] pc_out;
    logic        fault;
    logic [31:0] instret;
    logic [2:0]  fsm_state;

    int checks;
    int errors;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus.master),
        .exec_done   (exec_done),
        .PCSrc       (PCSrc),
        .ImmExt      (ImmExt),
        .instr_valid (instr_valid),
        .instr       (instr),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .pc_out      (pc_out),
        .fault       (fault),
        .instret     (instret),
        .fsm_state   (fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: called in FETCH; request accepted next edge, data returned the edge after.
    task automatic do_fetch(input logic [31:0] word);
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word;
        tick();
        bus.imem_rvalid = 1'b0;
    endtask

    task automatic do_retire(input logic src, input logic [31:0] imm);
        exec_done = 1'b1;
        PCSrc     = src;
        ImmExt    = imm;
        tick();
        exec_done = 1'b0;
        PCSrc     = 1'b0;
        ImmExt    = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
        exec_done = 1'b0; PCSrc = 1'b0; ImmExt = 32'd0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, S_IDLE); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
        checks++; if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret: got %h expected 0", instret); end
        repeat (2) tick();
        rst_n = 1'b1;
        bus.imem_ready = 1'b1;
        tick();
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 0", bus.imem_addr); end
        tick();
        checks++; if (fsm_state !== S_WAIT) begin errors++; $display("FAIL first_wait: got %0d expected %0d", fsm_state, S_WAIT); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL wait_req: got %b expected 0", bus.imem_req); end
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00A0_0093;
        tick();
        bus.imem_rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", instr_valid); end
        checks++; if (instr !== 32'h00A0_0093) begin errors++; $display("FAIL first_instr: got %h expected 00a00093", instr); end
        checks++; if (opcode !== 7'h13) begin errors++; $display("FAIL first_opcode: got %h expected 13", opcode); end
        checks++; if (func3 !== 3'd0) begin errors++; $display("FAIL first_func3: got %h expected 0", func3); end
        checks++; if (func7 !== 7'h00) begin errors++; $display("FAIL first_func7: got %h expected 0", func7); end
    endtask

    task automatic test_flow();
        do_retire(1'b0, 32'h0);
        checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr: got %h expected 4", bus.imem_addr); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq_req: got %b expected 1", bus.imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_valid_clr: got %b expected 0", instr_valid); end
        checks++; if (instret !== 32'd1) begin errors++; $display("FAIL seq_instret: got %0d expected 1", instret); end
        do_fetch(32'hFE00_0EE3);
        checks++; if (opcode !== 7'h63) begin errors++; $display("FAIL br_opcode: got %h expected 63", opcode); end
        checks++; if (func7 !== 7'h7F) begin errors++; $display("FAIL br_func7: got %h expected 7f", func7); end
        do_retire(1'b1, 32'hFFFF_FFFC);
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL taken_addr: got %h expected 0", bus.imem_addr); end
        checks++; if (instret !== 32'd2) begin errors++; $display("FAIL taken_instret: got %0d expected 2", instret); end
    endtask

    task automatic test_backpressure();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.imem_rvalid = (i == 2);
            bus.imem_rdata  = 32'hDEAD_BEEF;
            exec_done       = (i == 3);
            PCSrc           = 1'b1;
            ImmExt          = 32'h100;
            tick();
            checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL bp_req[%0d]: got %b expected 1", i, bus.imem_req); end
            checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL bp_addr[%0d]: got %h expected 0", i, bus.imem_addr); end
        end
        bus.imem_rvalid = 1'b0; exec_done = 1'b0; PCSrc = 1'b0; ImmExt = 32'd0;
        checks++; if (instr !== 32'hFE00_0EE3) begin errors++; $display("FAIL bp_spurious_instr: got %h expected fe000ee3", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_spurious_valid: got %b expected 0", instr_valid); end
        checks++; if (instret !== 32'd2) begin errors++; $display("FAIL bp_exec_ignored: got %0d expected 2", instret); end
        // Response coinciding with acceptance must be dropped.
        bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0;
        checks++; if (fsm_state !== S_WAIT) begin errors++; $display("FAIL bp_accept_state: got %0d expected %0d", fsm_state, S_WAIT); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_same_cycle_valid: got %b expected 0", instr_valid); end
        checks++; if (instr !== 32'hFE00_0EE3) begin errors++; $display("FAIL bp_same_cycle_instr: got %h expected fe000ee3", instr); end
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0020_A023;
        tick();
        bus.imem_rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_capture_valid: got %b expected 1", instr_valid); end
        checks++; if (func3 !== 3'd2) begin errors++; $display("FAIL bp_func3: got %0d expected 2", func3); end
        checks++; if (opcode !== 7'h23) begin errors++; $display("FAIL bp_opcode: got %h expected 23", opcode); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) begin
            PCSrc = 1'b1; ImmExt = 32'h40;
            bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1234_5678;
            tick();
            checks++; if (instr !== 32'h0020_A023) begin errors++; $display("FAIL stall_instr[%0d]: got %h expected 0020a023", i, instr); end
            checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected 0", i, pc_out); end
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, instr_valid); end
        end
        bus.imem_rvalid = 1'b0; PCSrc = 1'b0; ImmExt = 32'd0;
    endtask

    task automatic test_wrap();
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        #1;
        checks++; if (instret !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffffffff", instret); end
        do_retire(1'b0, 32'h0);
        checks++; if (instret !== 32'h0) begin errors++; $display("FAIL wrap_instret: got %h expected 0", instret); end
        checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL wrap_addr: got %h expected 4", bus.imem_addr); end
        do_fetch(32'h4020_8133);
        checks++; if (func7 !== 7'h20) begin errors++; $display("FAIL sub_func7: got %h expected 20", func7); end
        checks++; if (opcode !== 7'h33) begin errors++; $display("FAIL sub_opcode: got %h expected 33", opcode); end
        do_retire(1'b0, 32'h0);
        do_fetch(32'h0000_0013);
        checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL pc8_hold: got %h expected 8", pc_out); end
    endtask

    task automatic test_misaligned();
        do_retire(1'b1, 32'h2);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL mis_fault: got %b expected 1", fault); end
        checks++; if (pc_out !== 32'hA) begin errors++; $display("FAIL mis_pc: got %h expected a", pc_out); end
        checks++; if (instret !== 32'd2) begin errors++; $display("FAIL mis_instret: got %0d expected 2", instret); end
        for (int i = 0; i < 10; i++) begin
            bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b1; exec_done = 1'b1;
            tick();
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL err_req[%0d]: got %b expected 0", i, bus.imem_req); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL err_valid[%0d]: got %b expected 0", i, instr_valid); end
            checks++; if (fault !== 1'b1) begin errors++; $display("FAIL err_fault[%0d]: got %b expected 1", i, fault); end
            checks++; if (fsm_state !== S_ERROR) begin errors++; $display("FAIL err_state[%0d]: got %0d expected %0d", i, fsm_state, S_ERROR); end
        end
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; exec_done = 1'b0;
    endtask

    task automatic test_mid_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        checks++; if (fsm_state !== S_WAIT) begin errors++; $display("FAIL mr_in_wait: got %0d expected %0d", fsm_state, S_WAIT); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL mr_async_state: got %0d expected %0d", fsm_state, S_IDLE); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL mr_async_fault: got %b expected 0", fault); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL mr_async_pc: got %h expected 0", pc_out); end
        tick();
        rst_n = 1'b1;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mr_stale_valid: got %b expected 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL mr_stale_instr: got %h expected 0", instr); end
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL mr_fresh_req: got %b expected 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL mr_fresh_addr: got %h expected 0", bus.imem_addr); end
        bus.imem_rvalid = 1'b0;
        do_fetch(32'h00A0_0093);
        checks++; if (instr !== 32'h00A0_0093) begin errors++; $display("FAIL mr_refetch: got %h expected 00a00093", instr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_flow();
        test_backpressure();
        test_stall();
        test_wrap();
        test_misaligned();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
